scene_compositor: RTL
=====================

# scene_compositor

Pixel-level back end of the runner game. Merges the background, player sprite and two encounter sprite layers into one registered 12-bit VGA colour, detects player/encounter pixel overlap, and runs the hit/lives state machine. It drives the `hit` input that freezes every encounter module and the player. It sits directly downstream of the encounter and player sprite modules and directly upstream of the VGA output pins.

## Interface
Parameters:
- `LIVES`, 3: lives at reset and at restart; legal range 1..3.
- `FREEZE_FRAMES`, 60: frames the scene stays frozen after a hit; legal range 1..255.
- `GRACE_FRAMES`, 90: frames after reset, unfreeze or restart during which collisions are ignored; legal range 0..255.

Ports (all 4-bit colour buses are one nibble per channel):
- `clock`, in, 1: pixel clock, single clock domain.
- `reset`, in, 1: synchronous, active-high.
- `display_col`, in, 12: current column from the VGA timing generator.
- `display_row`, in, 11: current row from the VGA timing generator.
- `visible`, in, 1: active video.
- `bg_red`, `bg_green`, `bg_blue`, in, 4 each: background layer colour.
- `player_red`, `player_green`, `player_blue`, in, 4 each: player layer colour.
- `player_visible`, in, 1: player pixel is opaque.
- `enc1_red`, `enc1_green`, `enc1_blue`, in, 4 each: encounter 1 layer colour.
- `enc1_visible`, in, 1: encounter 1 pixel is opaque.
- `enc2_red`, `enc2_green`, `enc2_blue`, in, 4 each: encounter 2 layer colour.
- `enc2_visible`, in, 1: encounter 2 pixel is opaque.
- `restart_key`, in, 1: level input that leaves GAME_OVER.
- `vga_red`, `vga_green`, `vga_blue`, out, 4 each: registered output colour.
- `hit`, out, 1: freeze request to all sprite modules.
- `game_over`, out, 1: high in GAME_OVER.
- `lives`, out, 2: remaining lives.

## Operation
Frame start:
- `fs` = `display_col`==0 && `display_row`==0.
- All frame-granular state updates only on `fs` cycles.

Layer priority, evaluated when `visible`:
- player over enc1 over enc2 over background.
- Not `visible`: colour 0.

Blink:
- A 1-bit frame toggle flips on every `fs`. It resets to 0.
- In HIT_FREEZE, opaque player pixels output F,0,0 when the toggle is 1; otherwise they output the normal player colour.

Collision:
- `coll` = `visible` && `player_visible` && (`enc1_visible` || `enc2_visible`).
- `pending` is set on `coll` only while in PLAY with grace==0.
- On an `fs` cycle, `pending` loads that cycle's qualified `coll` (the old value is discarded). Otherwise `pending` = `pending` | qualified `coll`.

State machine, with transitions taken on `fs` only:
- PLAY:
  - If `pending`, decrement `lives`.
  - If the result is 0, go to GAME_OVER. Otherwise go to HIT_FREEZE and load freeze = FREEZE_FRAMES.
  - Else, if grace > 0, decrement grace.
- HIT_FREEZE:
  - Decrement freeze.
  - When the decremented value is 0, go to PLAY and load grace = GRACE_FRAMES.
- GAME_OVER:
  - If `restart_key`=1, go to PLAY, set `lives` = LIVES, grace = GRACE_FRAMES.
  - Otherwise stay.

Outputs:
- `hit` = state is HIT_FREEZE or GAME_OVER.
- `game_over` = state is GAME_OVER.

Counters:
- freeze and grace are 8-bit and never wrap below 0.
- `lives` never wraps below 0.

## Timing
- Reset values:
  - outputs: `vga_*`=0, `hit`=0, `game_over`=0, `lives`=LIVES.
  - internal: state PLAY, grace=GRACE_FRAMES, freeze=0, `pending`=0, toggle=0.
- Colour latency is exactly 1 clock: inputs at cycle N appear on `vga_*` at N+1.
- `hit`, `game_over` and `lives` update at the clock edge ending the `fs` cycle. They are registered.
- A collision in frame K is acted on at the `fs` that begins frame K+1.
- A collision on the `fs` cycle itself belongs to the new frame.
- `restart_key` is sampled only on `fs`. A pulse that misses `fs` is ignored.
- Reset mid-frame or mid-freeze returns to the reset values on the next edge. No partial state survives.
- Multiple collision pixels in one frame cost one life.

## Structure
Shared package `scream_pkg`:
- state encoding PLAY=2'd0, HIT_FREEZE=2'd1, GAME_OVER=2'd2.
- colour constant HIT_TINT=12'h00F (blue,green,red ordering).

Sub-module `hit_fsm`: contains the state, lives, freeze, grace and `pending` logic.

The top level keeps the priority mux, blink and output registers.

## Test plan
- **Priority:** `visible`=1, player, enc1 and background all active -> next cycle `vga_*` equals the player colour. Drop `player_visible` -> enc1 colour. Drop `visible` -> 0,0,0.
- **Grace:** overlap in every frame for the first 90 frames after reset -> `lives` stays 3 and `hit` stays 0. Overlap in frame 91 -> at the next `fs`, `lives`=2 and `hit`=1.
- **Freeze:** after the hit, `hit` stays 1 for exactly 60 `fs` events, then drops. Overlap during the freeze does not change `lives`. The player blinks red on alternate frames.
- **Game over:** LIVES=1, one overlap after grace -> `game_over`=1, `hit`=1, `lives`=0. `restart_key` held across an `fs` -> PLAY, `lives`=1, `hit`=0.
- **Edge cases:**
  - Collision only on the `fs` cycle -> counted for the new frame, and the life is lost at the following `fs`.
  - Reset asserted mid-freeze -> `hit`=0 and `lives`=LIVES on the next edge.

Source files
------------

// File: rtl/scream_pkg.sv
// Shared types and constants for the runner game's pixel back end.
package scream_pkg;

    typedef enum logic [1:0] {
        Play      = 2'd0,
        HitFreeze = 2'd1,
        GameOver  = 2'd2
    } game_state_e;

    // Packed {blue, green, red}: pure red.
    localparam logic [11:0] HitTint = 12'h00F;

    function automatic logic [7:0] sat_dec8(input logic [7:0] v);
        return (v == 8'd0) ? 8'd0 : v - 8'd1;
    endfunction

endpackage

// File: rtl/hit_fsm.sv
// Hit/lives state machine: frame-granular lives, freeze and grace counters plus the
// per-frame collision latch.
module hit_fsm
    import scream_pkg::*;
#(
    parameter int unsigned LIVES         = 3,
    parameter int unsigned FREEZE_FRAMES = 60,
    parameter int unsigned GRACE_FRAMES  = 90
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fs_i,
    input  logic        coll_i,
    input  logic        restart_i,
    output game_state_e state_o,
    output logic [1:0]  lives_o,
    output logic        hit_o,
    output logic        game_over_o
);

    localparam logic [1:0] LivesInit  = 2'(LIVES);
    localparam logic [7:0] FreezeInit = 8'(FREEZE_FRAMES);
    localparam logic [7:0] GraceInit  = 8'(GRACE_FRAMES);

    game_state_e state_q, state_d;
    logic [1:0]  lives_q, lives_d;
    logic [7:0]  freeze_q, freeze_d;
    logic [7:0]  grace_q, grace_d;
    logic        pending_q, pending_d;

    logic        coll_qual;
    logic [1:0]  lives_dec;
    logic [7:0]  freeze_dec;

    always_comb begin
        state_d    = state_q;
        lives_d    = lives_q;
        freeze_d   = freeze_q;
        grace_d    = grace_q;
        coll_qual  = coll_i && (state_q == Play) && (grace_q == 8'd0);
        lives_dec  = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
        freeze_dec = sat_dec8(freeze_q);
        // A collision on the frame-start cycle belongs to the frame it opens.
        pending_d  = fs_i ? coll_qual : (pending_q | coll_qual);

        if (fs_i) begin
            case (state_q)
                Play: begin
                    if (pending_q) begin
                        lives_d = lives_dec;
                        if (lives_dec == 2'd0) begin
                            state_d = GameOver;
                        end else begin
                            state_d  = HitFreeze;
                            freeze_d = FreezeInit;
                        end
                    end else begin
                        grace_d = sat_dec8(grace_q);
                    end
                end
                HitFreeze: begin
                    freeze_d = freeze_dec;
                    if (freeze_dec == 8'd0) begin
                        state_d = Play;
                        grace_d = GraceInit;
                    end
                end
                GameOver: begin
                    if (restart_i) begin
                        state_d = Play;
                        lives_d = LivesInit;
                        grace_d = GraceInit;
                    end
                end
                default: state_d = Play;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= Play;
            lives_q   <= LivesInit;
            freeze_q  <= 8'd0;
            grace_q   <= GraceInit;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lives_q   <= lives_d;
            freeze_q  <= freeze_d;
            grace_q   <= grace_d;
            pending_q <= pending_d;
        end
    end

    assign state_o     = state_q;
    assign lives_o     = lives_q;
    assign hit_o       = (state_q == HitFreeze) || (state_q == GameOver);
    assign game_over_o = (state_q == GameOver);

endmodule

// File: rtl/scene_compositor.sv
// Layer compositor for the runner game: priority mux, hit blink and registered VGA colour,
// with collision detection feeding the hit/lives state machine.
module scene_compositor
    import scream_pkg::*;
#(
    parameter int unsigned LIVES         = 3,
    parameter int unsigned FREEZE_FRAMES = 60,
    parameter int unsigned GRACE_FRAMES  = 90
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] display_col,
    input  logic [10:0] display_row,
    input  logic        visible,
    input  logic [3:0]  bg_red,
    input  logic [3:0]  bg_green,
    input  logic [3:0]  bg_blue,
    input  logic [3:0]  player_red,
    input  logic [3:0]  player_green,
    input  logic [3:0]  player_blue,
    input  logic        player_visible,
    input  logic [3:0]  enc1_red,
    input  logic [3:0]  enc1_green,
    input  logic [3:0]  enc1_blue,
    input  logic        enc1_visible,
    input  logic [3:0]  enc2_red,
    input  logic [3:0]  enc2_green,
    input  logic [3:0]  enc2_blue,
    input  logic        enc2_visible,
    input  logic        restart_key,
    output logic [3:0]  vga_red,
    output logic [3:0]  vga_green,
    output logic [3:0]  vga_blue,
    output logic        hit,
    output logic        game_over,
    output logic [1:0]  lives
);

    logic        fs;
    logic        coll;
    game_state_e state;
    logic        toggle_q, toggle_d;
    logic [11:0] colour_q, colour_d;

    assign fs   = (display_col == 12'd0) && (display_row == 11'd0);
    assign coll = visible && player_visible && (enc1_visible || enc2_visible);

    hit_fsm #(
        .LIVES        (LIVES),
        .FREEZE_FRAMES(FREEZE_FRAMES),
        .GRACE_FRAMES (GRACE_FRAMES)
    ) u_hit_fsm (
        .clock      (clock),
        .reset      (reset),
        .fs_i       (fs),
        .coll_i     (coll),
        .restart_i  (restart_key),
        .state_o    (state),
        .lives_o    (lives),
        .hit_o      (hit),
        .game_over_o(game_over)
    );

    always_comb begin
        toggle_d = fs ? ~toggle_q : toggle_q;
        colour_d = 12'h000;
        if (visible) begin
            if (player_visible) begin
                colour_d = (state == HitFreeze && toggle_q) ? HitTint
                                                            : {player_blue, player_green, player_red};
            end else if (enc1_visible) begin
                colour_d = {enc1_blue, enc1_green, enc1_red};
            end else if (enc2_visible) begin
                colour_d = {enc2_blue, enc2_green, enc2_red};
            end else begin
                colour_d = {bg_blue, bg_green, bg_red};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            toggle_q <= 1'b0;
            colour_q <= 12'h000;
        end else begin
            toggle_q <= toggle_d;
            colour_q <= colour_d;
        end
    end

    assign vga_red   = colour_q[3:0];
    assign vga_green = colour_q[7:4];
    assign vga_blue  = colour_q[11:8];

endmodule
